regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core: `NRD` combinational read ports, two write ports, a per-register busy scoreboard for pipelined writeback, and a hardware clear sequencer that zeroes the array after reset or on request. It replaces the single-write, edge-inverted register file in the decode/writeback path. The array carries no per-entry reset, so it can be inferred as distributed RAM.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 39 +++
 rtl/regfile_clear_fsm.sv | 55 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: clear-sequencer state
// encoding, default geometry and the address-width helper.
package regfile_pkg;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;
  localparam int RF_NRD_DEF   = 2;

  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_READY = 1'b1;

  function automatic int rf_addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/writeback pipeline (master) and the register
// file (slave): read ports, two write ports, allocation and clear request.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF
) ();

  localparam int AW = rf_addr_width(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                clr_req;
  logic                ready;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           alloc_en, alloc_addr, clr_req,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           alloc_en, alloc_addr, clr_req,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps idx over 1..NREGS-1 writing zeros after reset or a
// clear request, then holds READY until the next request.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int AW    = rf_addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          clr_start_o
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Termination compares against NREGS-1 so idx never has to wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == RF_CLEAR) begin
      if (idx_q == LastIdx) begin
        state_d = RF_READY;
        idx_d   = AW'(1);
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end else if (clr_req_i) begin
      state_d = RF_CLEAR;
      idx_d   = AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign ready_o     = (state_q == RF_READY);
  assign clr_we_o    = (state_q == RF_CLEAR) & rst;
  assign clr_idx_o   = idx_q;
  assign clr_start_o = ready_o & clr_req_i;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and clear sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int AW = rf_addr_width(NREGS);

  logic            ready, clr_we, clr_start;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic            wr0_ok, wr1_ok, rd_valid;
  logic [NRD*XLEN-1:0] rd_data_w;
  logic [NRD-1:0]      rd_busy_w;

  regfile_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (bus.clr_req),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_idx_o  (clr_idx),
    .clr_start_o(clr_start)
  );

  assign wr0_ok   = ready & bus.wr0_en & (bus.wr0_addr != '0);
  assign wr1_ok   = ready & bus.wr1_en & (bus.wr1_addr != '0);
  assign rd_valid = ready & rst;

  // No per-entry reset so the array can map onto distributed RAM; port 1 is
  // written last and therefore wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else begin
      if (wr0_ok) mem_q[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_ok) mem_q[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_start) begin
      busy_d = '0;
    end else if (ready) begin
      if (wr0_ok)       busy_d[bus.wr0_addr]   = 1'b0;
      if (wr1_ok)       busy_d[bus.wr1_addr]   = 1'b0;
      if (bus.alloc_en) busy_d[bus.alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = bus.rd_addr[p*AW +: AW];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (rd_valid && (addr != '0)) begin
        data = mem_q[addr];
        busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && (bus.wr1_addr == addr)) begin
          data = bus.wr1_data;
          busy = bus.alloc_en && (bus.alloc_addr == addr);
        end else if (wr0_ok && (bus.wr0_addr == addr)) begin
          data = bus.wr0_data;
          busy = bus.alloc_en && (bus.alloc_addr == addr);
        end
`endif
      end
    end

    assign rd_data_w[p*XLEN +: XLEN] = data;
    assign rd_busy_w[p]              = busy;
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
  assign bus.ready   = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: an architectural model of the register
// file checked every cycle, plus directed vectors with literal expectations.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Architectural model: contents, busy bits, and cycles left until ready.
  logic [XLEN-1:0]  modelMem [NREGS];
  logic [NREGS-1:0] modelBusy = '0;
  bit               modelReady = 1'b0;
  int               sweepLeft  = NREGS - 1;

  always @(posedge clk) begin
    if (!rst) begin
      modelReady = 1'b0;
      sweepLeft  = NREGS - 1;
      modelBusy  = '0;
    end else if (!modelReady) begin
      sweepLeft--;
      if (sweepLeft == 0) begin
        modelReady = 1'b1;
        foreach (modelMem[i]) modelMem[i] = '0;
      end
    end else if (bus.clr_req) begin
      modelReady = 1'b0;
      sweepLeft  = NREGS - 1;
      modelBusy  = '0;
    end else begin
      if (bus.wr0_en && bus.wr0_addr != 0) begin
        modelMem[bus.wr0_addr]  = bus.wr0_data;
        modelBusy[bus.wr0_addr] = 1'b0;
      end
      if (bus.wr1_en && bus.wr1_addr != 0) begin
        modelMem[bus.wr1_addr]  = bus.wr1_data;
        modelBusy[bus.wr1_addr] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_addr != 0) modelBusy[bus.alloc_addr] = 1'b1;
    end
  end

  function automatic void expectRead(input logic [AW-1:0] a,
                                     output logic [XLEN-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (rst && modelReady && a != 0) begin
      d = modelMem[a];
      b = modelBusy[a];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr1_en && bus.wr1_addr == a) begin
        d = bus.wr1_data;
        b = bus.alloc_en && bus.alloc_addr == a;
      end else if (bus.wr0_en && bus.wr0_addr == a) begin
        d = bus.wr0_data;
        b = bus.alloc_en && bus.alloc_addr == a;
      end
`endif
    end
  endfunction

  always @(negedge clk) begin
    logic [XLEN-1:0] ed;
    logic            eb;
    if (checkEn) begin
      checks++;
      if (bus.ready !== modelReady) begin
        failures++;
        $display("[TB] FAIL model_ready t=%0t actual=%b expected=%b", $time, bus.ready, modelReady);
      end
      for (int p = 0; p < NRD; p++) begin
        expectRead(bus.rd_addr[p*AW +: AW], ed, eb);
        checks++;
        if (bus.rd_data[p*XLEN +: XLEN] !== ed) begin
          failures++;
          $display("[TB] FAIL model_rd_data[%0d] t=%0t addr=%0d actual=%h expected=%h",
                   p, $time, bus.rd_addr[p*AW +: AW], bus.rd_data[p*XLEN +: XLEN], ed);
        end
        checks++;
        if (bus.rd_busy[p] !== eb) begin
          failures++;
          $display("[TB] FAIL model_rd_busy[%0d] t=%0t addr=%0d actual=%b expected=%b",
                   p, $time, bus.rd_addr[p*AW +: AW], bus.rd_busy[p], eb);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
                               input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
                               input logic ae, input logic [AW-1:0] aa, input logic cr);
    bus.wr0_en = w0e; bus.wr0_addr = w0a; bus.wr0_data = w0d;
    bus.wr1_en = w1e; bus.wr1_addr = w1a; bus.wr1_data = w1d;
    bus.alloc_en = ae; bus.alloc_addr = aa; bus.clr_req = cr;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic setRead(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSweep(input string name);
    for (int k = 1; k < NREGS - 1; k++) begin
      stepCycle();
      checkOutput(name, {31'b0, bus.ready}, 32'd0);
    end
    stepCycle();
    checkOutput({name, "_done"}, {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    idleInputs();
    bus.rd_addr = '0;
    rst = 1'b0;
    repeat (3) stepCycle();
    checkEn = 1'b1;
    checkOutput("reset_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("reset_rd_data", bus.rd_data[31:0], 32'd0);
    checkOutput("reset_rd_busy", {30'b0, bus.rd_busy}, 32'd0);

    rst = 1'b1;
    waitSweep("initial_sweep");

    setRead(0, 5'd5);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_x5", bus.rd_data[31:0], 32'hDEADBEEF);
`else
    checkOutput("nobypass_x5", bus.rd_data[31:0], 32'h0);
`endif
    stepCycle();
    idleInputs();
    #1;
    checkOutput("read_x5", bus.rd_data[31:0], 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(0, 5'd0);
    stepCycle();
    idleInputs();
    #1;
    checkOutput("read_x0", bus.rd_data[31:0], 32'h0);

    applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, '0, 1'b0);
    stepCycle();
    idleInputs();
    setRead(1, 5'd7);
    #1;
    checkOutput("collide_x7", bus.rd_data[63:32], 32'h22);

    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    stepCycle();
    idleInputs();
    setRead(1, 5'd9);
    #1;
    checkOutput("alloc_x9_busy", {31'b0, bus.rd_busy[1]}, 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0, 1'b0);
    stepCycle();
    idleInputs();
    #1;
    checkOutput("write_x9_busy", {31'b0, bus.rd_busy[1]}, 32'd0);
    checkOutput("write_x9_data", bus.rd_data[63:32], 32'h99);
    applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    stepCycle();
    idleInputs();
    #1;
    checkOutput("alloc_write_x9_busy", {31'b0, bus.rd_busy[1]}, 32'd1);

    // Fill x1..x31, mark x12 busy, then sweep with a write lost mid-sweep.
    for (int i = 1; i < NREGS; i += 2) begin
      applyStimulus(1'b1, AW'(i), 32'h1000_0000 + i,
                    (i + 1 < NREGS), AW'(i + 1), 32'h1000_0000 + i + 1,
                    1'b1, 5'd12, 1'b0);
      stepCycle();
    end
    idleInputs();
    setRead(0, 5'd4);
    setRead(1, 5'd12);
    #1;
    checkOutput("filled_x4", bus.rd_data[31:0], 32'h1000_0004);
    checkOutput("filled_x12_busy", {31'b0, bus.rd_busy[1]}, 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    checkOutput("clr_ready_drop", {31'b0, bus.ready}, 32'd0);
    applyStimulus(1'b1, 5'd4, 32'h1234, 1'b0, '0, '0, 1'b1, 5'd12, 1'b1);
    stepCycle();
    idleInputs();
    for (int k = 2; k < NREGS - 1; k++) stepCycle();
    checkOutput("clr_sweep_ready_low", {31'b0, bus.ready}, 32'd0);
    stepCycle();
    checkOutput("clr_sweep_ready_high", {31'b0, bus.ready}, 32'd1);
    for (int a = 0; a < NREGS; a++) begin
      setRead(0, AW'(a));
      #1;
      checkOutput("cleared_data", bus.rd_data[31:0], 32'h0);
      checkOutput("cleared_busy", {31'b0, bus.rd_busy[0]}, 32'd0);
      stepCycle();
    end

    // Reset once the sweep has reached idx 10 restarts the full sweep.
    applyStimulus(1'b1, 5'd2, 32'h55, 1'b0, '0, '0, 1'b1, 5'd6, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    idleInputs();
    repeat (9) stepCycle();
    rst = 1'b0;
    stepCycle();
    rst = 1'b1;
    waitSweep("restart_sweep");
    setRead(0, 5'd2);
    setRead(1, 5'd6);
    #1;
    checkOutput("restart_x2", bus.rd_data[31:0], 32'h0);
    checkOutput("restart_x6_busy", {31'b0, bus.rd_busy[1]}, 32'd0);

    applyStimulus(1'b1, 5'd3, 32'h0BADF00D, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    stepCycle();
    setRead(0, 5'd3);
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("same_cycle_x3", bus.rd_data[31:0], 32'hA5A5A5A5);
`else
    checkOutput("same_cycle_x3", bus.rd_data[31:0], 32'h0BADF00D);
`endif
    stepCycle();
    idleInputs();
    #1;
    checkOutput("after_edge_x3", bus.rd_data[31:0], 32'hA5A5A5A5);
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
